// File: rtl/if_id_queue_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : if_id_queue_if
// Purpose  : Bundles the fetch-side and decode-side handshake signals of the
//            fetch-to-decode instruction queue.
// Signals  : in_valid/in_ready/in_pc/in_instr  - fetch offer handshake
//            flush                             - redirect, discard contents
//            out_valid/out_ready/out_pc/out_instr - decode head handshake
//            count                             - occupancy
//            halted                            - sticky ebreak retirement flag
// Modports : slave  - the queue itself
//            master - the surrounding fetch/decode logic (or a testbench)
// Revision : 1.0 - initial release
// ============================================================================
interface if_id_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int C_CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [XLEN-1:0]    in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_instr;
  logic [C_CNT_W-1:0] count;
  logic               halted;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count, halted
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count, halted
  );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : if_id_queue
// Purpose  : Registered {pc, instr} queue between fetch and decode. Circular
//            buffer with separate occupancy counter, flush on redirect, and a
//            sticky halt once an ebreak is consumed by decode.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - if_id_queue_if.slave (fetch offer, decode head, flush,
//                   count, halted)
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int              DEPTH  = 4,
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] EBREAK = 'h0010_0073
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave bus
);

  localparam int                 C_PTR_W   = $clog2(DEPTH);
  localparam int                 C_CNT_W   = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "if_id_queue: DEPTH must be a power of two >= 2");
  end

  // Entry storage; contents are don't-care after reset so no reset is applied.
  logic [XLEN-1:0]    pc_mem_q    [DEPTH];
  logic [XLEN-1:0]    instr_mem_q [DEPTH];

  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_CNT_W-1:0] count_q,  count_d;
  logic               halted_q, halted_d;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;

  always_comb begin
    // Both handshake flags come from registered state only, so there is no
    // combinational path from out_ready back to in_ready.
    w_in_ready  = (count_q != C_FULL) && !halted_q;
    w_out_valid = (count_q != '0) && !halted_q;
    w_push      = bus.in_valid && w_in_ready && !bus.flush;
    w_pop       = w_out_valid && bus.out_ready;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    // A halted queue is completely frozen, including against flush.
    if (bus.flush && !halted_q) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Halt is triggered when decode actually takes the ebreak, which also
    // covers a pop that coincides with a flush.
    halted_d = halted_q || (w_pop && (instr_mem_q[rd_ptr_q] == EBREAK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      pc_mem_q[wr_ptr_q]    <= bus.in_pc;
      instr_mem_q[wr_ptr_q] <= bus.in_instr;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign bus.out_instr = w_out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;
  assign bus.halted    = halted_q;

endmodule
`default_nettype wire
